// File: rtl/hs_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hs_arb_pkg
// Description : Shared types and defaults for the two-phase handshake arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package hs_arb_pkg;

    // Default data width of every channel.
    localparam int unsigned c_DEFAULT_WIDTH       = 8;
    // Default flop count of each request/ack synchronizer (two is the floor).
    localparam int unsigned c_DEFAULT_SYNC_STAGES = 2;

    // Arbiter FSM: IDLE arbitrates, WAIT holds one output transaction open.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage : hs_arb_pkg
`default_nettype wire

// File: rtl/hs_sync.sv
`default_nettype none
// ============================================================================
// Module      : hs_sync
// Description : N-flop single-bit synchronizer with asynchronous active-low
//               reset, used on every handshake line crossing into clk.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_sync #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_chain;

    // Shift the asynchronous input through the flop chain; the last flop is safe to use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[N-2:0], i_d};
        end
    end

    assign o_q = r_chain[N-1];

endmodule : hs_sync
`default_nettype wire

// File: rtl/hs_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hs_arbiter
// Description : Round-robin arbiter merging two two-phase (toggle) handshake
//               producers onto one two-phase channel toward a shared FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_arbiter
    import hs_arb_pkg::*;
#(
    parameter int unsigned WIDTH       = c_DEFAULT_WIDTH,
    parameter int unsigned SYNC_STAGES = c_DEFAULT_SYNC_STAGES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_In0_HS_Req,
    output logic             io_In0_HS_Ack,
    input  logic [WIDTH-1:0] io_In0_Data,
    input  logic             io_In1_HS_Req,
    output logic             io_In1_HS_Ack,
    input  logic [WIDTH-1:0] io_In1_Data,
    output logic             io_Out_HS_Req,
    input  logic             io_Out_HS_Ack,
    output logic [WIDTH-1:0] io_Out_Data,
    output logic             io_Grant,
    output logic             io_Busy
);

    // ------------------------------------------------------------------
    // Synchronized handshake inputs
    // ------------------------------------------------------------------
    logic w_in0_req_s;
    logic w_in1_req_s;
    logic w_out_ack_s;

    hs_sync #(.N(SYNC_STAGES)) u_sync_in0_req (
        .clk   (clock),
        .rst_n (reset),
        .i_d   (io_In0_HS_Req),
        .o_q   (w_in0_req_s)
    );

    hs_sync #(.N(SYNC_STAGES)) u_sync_in1_req (
        .clk   (clock),
        .rst_n (reset),
        .i_d   (io_In1_HS_Req),
        .o_q   (w_in1_req_s)
    );

    hs_sync #(.N(SYNC_STAGES)) u_sync_out_ack (
        .clk   (clock),
        .rst_n (reset),
        .i_d   (io_Out_HS_Ack),
        .o_q   (w_out_ack_s)
    );

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_out_req;
    logic             w_out_req_nxt;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] w_out_data_nxt;
    logic             r_in0_ack;
    logic             w_in0_ack_nxt;
    logic             r_in1_ack;
    logic             w_in1_ack_nxt;
    logic             r_grant;
    logic             w_grant_nxt;
    logic             r_rr;
    logic             w_rr_nxt;
    logic             r_busy;

    logic             w_pend0;
    logic             w_pend1;
    logic             w_sel;

    // A producer is pending while its synchronized Req differs from the Ack we drive.
    assign w_pend0 = (w_in0_req_s != r_in0_ack);
    assign w_pend1 = (w_in1_req_s != r_in1_ack);

    // Next-state and next-output decode; every register holds unless a case below moves it.
    always_comb begin
        w_state_nxt    = r_state;
        w_out_req_nxt  = r_out_req;
        w_out_data_nxt = r_out_data;
        w_in0_ack_nxt  = r_in0_ack;
        w_in1_ack_nxt  = r_in1_ack;
        w_grant_nxt    = r_grant;
        w_rr_nxt       = r_rr;
        w_sel          = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_pend0 || w_pend1) begin
                    // Contention goes to the round-robin pointer, otherwise to the lone requester.
                    w_sel          = (w_pend0 && w_pend1) ? r_rr : w_pend1;
                    w_out_data_nxt = w_sel ? io_In1_Data : io_In0_Data;
                    w_out_req_nxt  = ~r_out_req;
                    w_grant_nxt    = w_sel;
                    w_state_nxt    = WAIT;
                end
            end
            WAIT: begin
                // The FIFO has answered once its synchronized Ack catches up with our Req.
                if (w_out_ack_s == r_out_req) begin
                    if (r_grant) begin
                        w_in1_ack_nxt = ~r_in1_ack;
                    end else begin
                        w_in0_ack_nxt = ~r_in0_ack;
                    end
                    w_rr_nxt    = ~r_grant;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output and pointer registers; Busy is registered from the next state so it has no input path.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_req  <= 1'b0;
            r_out_data <= '0;
            r_in0_ack  <= 1'b0;
            r_in1_ack  <= 1'b0;
            r_grant    <= 1'b0;
            r_rr       <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_out_req  <= w_out_req_nxt;
            r_out_data <= w_out_data_nxt;
            r_in0_ack  <= w_in0_ack_nxt;
            r_in1_ack  <= w_in1_ack_nxt;
            r_grant    <= w_grant_nxt;
            r_rr       <= w_rr_nxt;
            r_busy     <= (w_state_nxt == WAIT);
        end
    end

    assign io_Out_HS_Req = r_out_req;
    assign io_Out_Data   = r_out_data;
    assign io_In0_HS_Ack = r_in0_ack;
    assign io_In1_HS_Ack = r_in1_ack;
    assign io_Grant      = r_grant;
    assign io_Busy       = r_busy;

endmodule : hs_arbiter
`default_nettype wire

// File: tb/tb_hs_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs_arbiter
// Description : Directed self-checking bench for hs_arbiter with a scoreboard
//               of expected (grant, data) pairs and a delayed-ack FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_arbiter;

    localparam int unsigned WIDTH       = 8;
    localparam int unsigned SYNC_STAGES = 2;

    typedef struct {
        logic             k;
        logic [WIDTH-1:0] d;
    } exp_t;

    logic             clock;
    logic             reset;
    logic             in0_req;
    logic             in1_req;
    logic [WIDTH-1:0] in0_data;
    logic [WIDTH-1:0] in1_data;
    logic             out_ack;
    logic             io_In0_HS_Ack;
    logic             io_In1_HS_Ack;
    logic             io_Out_HS_Req;
    logic [WIDTH-1:0] io_Out_Data;
    logic             io_Grant;
    logic             io_Busy;

    int   total = 0;
    int   bad   = 0;
    int   ack_delay = 5;
    int   out_toggles = 0;
    logic prev_out = 1'b0;
    logic exp_ack0 = 1'b0;
    logic exp_ack1 = 1'b0;
    logic last_k   = 1'b0;
    exp_t sb[$];

    hs_arbiter #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_In0_HS_Req (in0_req),
        .io_In0_HS_Ack (io_In0_HS_Ack),
        .io_In0_Data   (in0_data),
        .io_In1_HS_Req (in1_req),
        .io_In1_HS_Ack (io_In1_HS_Ack),
        .io_In1_Data   (in1_data),
        .io_Out_HS_Req (io_Out_HS_Req),
        .io_Out_HS_Ack (out_ack),
        .io_Out_Data   (io_Out_Data),
        .io_Grant      (io_Grant),
        .io_Busy       (io_Busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // FIFO model: echo the request back as the acknowledge after ack_delay.
    initial out_ack = 1'b0;
    always @(io_Out_HS_Req) begin
        #(ack_delay);
        out_ack = io_Out_HS_Req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Toggle a producer request with new data and record the expected output.
    task automatic drive(input logic k, input logic [WIDTH-1:0] d);
        exp_t e;
        e.k = k;
        e.d = d;
        if (k) begin
            in1_data = d;
            in1_req  = ~in1_req;
        end else begin
            in0_data = d;
            in0_req  = ~in0_req;
        end
        sb.push_back(e);
    endtask

    // Wait for the next Out_Req toggle and compare it against the scoreboard head.
    task automatic expect_out(input string tag, output int cyc);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 50) begin
            tick();
            cyc++;
            if (io_Out_HS_Req !== prev_out) seen = 1'b1;
        end
        chk({tag, "_out_toggle"}, 32'(seen), 32'd1);
        if (seen) begin
            prev_out = io_Out_HS_Req;
            out_toggles++;
            chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                last_k = e.k;
                chk({tag, "_grant"}, 32'(io_Grant), 32'(e.k));
                chk({tag, "_data"}, 32'(io_Out_Data), 32'(e.d));
            end
        end
    endtask

    // Wait for producer k's Ack toggle; report cycles taken and whether WAIT outputs held.
    task automatic wait_ack(input string tag, input logic k, output int cyc, output bit stable);
        logic             exp_new;
        logic [WIDTH-1:0] held;
        bit               seen;
        exp_new = k ? ~exp_ack1 : ~exp_ack0;
        held    = io_Out_Data;
        seen    = 1'b0;
        stable  = 1'b1;
        cyc     = 0;
        while (!seen && cyc < 100) begin
            tick();
            cyc++;
            if ((k ? io_In1_HS_Ack : io_In0_HS_Ack) === exp_new) begin
                seen = 1'b1;
            end else if (io_Out_Data !== held || io_Out_HS_Req !== prev_out || io_Busy !== 1'b1) begin
                stable = 1'b0;
            end
        end
        chk({tag, "_in_ack"}, 32'(seen), 32'd1);
        if (k) exp_ack1 = exp_new;
        else   exp_ack0 = exp_new;
    endtask

    // Assert reset with producers, check the cleared outputs, release and let syncs settle.
    task automatic apply_reset(input string tag);
        reset    = 1'b0;
        in0_req  = 1'b0;
        in1_req  = 1'b0;
        in0_data = '0;
        in1_data = '0;
        sb.delete();
        prev_out = 1'b0;
        exp_ack0 = 1'b0;
        exp_ack1 = 1'b0;
        tick();
        tick();
        chk({tag, "_outs_zero"},
            32'({io_Out_HS_Req, io_In0_HS_Ack, io_In1_HS_Ack, io_Grant, io_Busy, io_Out_Data}), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < int'(SYNC_STAGES) + 1; i++) tick();
    endtask

    initial begin
        int   cyc;
        bit   stable;
        int   cnt0;
        int   cnt1;
        logic k;

        reset    = 1'b0;
        in0_req  = 1'b0;
        in1_req  = 1'b0;
        in0_data = '0;
        in1_data = '0;
        #2;

        // Reset state.
        apply_reset("rst0");

        // Scenario 1: single transfer with latency checks.
        drive(1'b0, 8'hA5);
        expect_out("s1", cyc);
        chk("s1_req_lat", 32'(cyc), 32'(SYNC_STAGES + 1));
        chk("s1_busy", 32'(io_Busy), 32'd1);
        wait_ack("s1", 1'b0, cyc, stable);
        chk("s1_ack_lat", 32'(cyc), 32'(SYNC_STAGES + 1));
        chk("s1_ack0", 32'(io_In0_HS_Ack), 32'd1);
        chk("s1_idle", 32'(io_Busy), 32'd0);

        // Scenario 2: simultaneous requests, pointer back at producer 0.
        apply_reset("rst2");
        drive(1'b0, 8'h11);
        drive(1'b1, 8'h22);
        expect_out("s2a", cyc);
        wait_ack("s2a", 1'b0, cyc, stable);
        expect_out("s2b", cyc);
        chk("s2b_back_to_back", 32'(cyc), 32'd1);
        wait_ack("s2b", 1'b1, cyc, stable);

        // Scenario 3: saturation, both producers re-toggle right after each Ack.
        out_toggles = 0;
        drive(1'b0, 8'h30);
        drive(1'b1, 8'h80);
        cnt0 = 1;
        cnt1 = 1;
        for (int n = 0; n < 16; n++) begin
            expect_out("s3", cyc);
            k = last_k;
            wait_ack("s3", k, cyc, stable);
            if (k == 1'b0 && cnt0 < 8) begin
                drive(1'b0, 8'(8'h30 + cnt0));
                cnt0++;
            end else if (k == 1'b1 && cnt1 < 8) begin
                drive(1'b1, 8'(8'h80 + cnt1));
                cnt1++;
            end
        end
        chk("s3_toggles", 32'(out_toggles), 32'd16);
        chk("s3_sb_drained", 32'(sb.size()), 32'd0);

        // Scenario 4: producer 1 requests while producer 0 is in flight.
        drive(1'b0, 8'h55);
        expect_out("s4a", cyc);
        chk("s4_busy", 32'(io_Busy), 32'd1);
        drive(1'b1, 8'h66);
        wait_ack("s4a", 1'b0, cyc, stable);
        chk("s4_wait_stable", 32'(stable), 32'd1);
        expect_out("s4b", cyc);
        chk("s4b_next", 32'(cyc), 32'd1);
        wait_ack("s4b", 1'b1, cyc, stable);

        // Scenario 5: reset in the middle of WAIT.
        drive(1'b0, 8'h77);
        expect_out("s5", cyc);
        chk("s5_busy", 32'(io_Busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("s5_async_clear",
            32'({io_Out_HS_Req, io_In0_HS_Ack, io_In1_HS_Ack, io_Grant, io_Busy, io_Out_Data}), 32'd0);
        apply_reset("rst5");
        drive(1'b0, 8'h3C);
        expect_out("s5post", cyc);
        wait_ack("s5post", 1'b0, cyc, stable);
        chk("s5post_ack0", 32'(io_In0_HS_Ack), 32'd1);

        // Scenario 6: slow FIFO holds the channel open for a long time.
        ack_delay = 200;
        drive(1'b1, 8'h9A);
        expect_out("s6", cyc);
        wait_ack("s6", 1'b1, cyc, stable);
        chk("s6_wait_stable", 32'(stable), 32'd1);
        chk("s6_ack_after_delay", 32'(cyc >= 20), 32'd1);
        chk("s6_ack1", 32'(io_In1_HS_Ack), 32'd1);
        ack_delay = 5;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hs_arbiter
`default_nettype wire

// File: doc/hs_arbiter.md
HS_ARBITER -- requirements
Module: hs_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of every channel.
REQ-002 Parameter SYNC_STAGES, default 2: flop count of each request/ack synchronizer, minimum 2.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 io_In0_HS_Req  input  1  producer 0 two-phase request; a toggle means new data.
REQ-006 io_In0_HS_Ack  output  1  producer 0 two-phase acknowledge.
REQ-007 io_In0_Data  input  WIDTH  producer 0 bundled data; stable from the Req toggle until the Ack toggle.
REQ-008 io_In1_HS_Req / io_In1_HS_Ack / io_In1_Data: same as REQ-005 to REQ-007, for producer 1.
REQ-009 io_Out_HS_Req  output  1  two-phase request toward the shared FIFO input.
REQ-010 io_Out_HS_Ack  input  1  two-phase acknowledge from the FIFO; asynchronous to clock.
REQ-011 io_Out_Data  output  WIDTH  bundled data toward the FIFO.
REQ-012 io_Grant  output  1  index of the current or last granted producer.
REQ-013 io_Busy  output  1  high while an output transaction is outstanding.

Function
REQ-014 Each of In0_Req, In1_Req and Out_Ack shall pass through its own SYNC_STAGES-flop synchronizer before any use.
REQ-015 pending_k = (synchronized In_k_Req != io_In_k_HS_Ack).
REQ-016 FSM states: IDLE and WAIT only.
REQ-017 In IDLE with no pending request, the FSM shall stay in IDLE and all outputs shall hold.
REQ-018 In IDLE with only producer k pending, producer k shall be granted.
REQ-019 In IDLE with both producers pending, the producer indicated by the round-robin pointer rr shall be granted.
REQ-020 On a grant edge, in one cycle: io_Out_Data <= In_k_Data, io_Out_HS_Req toggles, io_Grant <= k, next state = WAIT.
REQ-021 In WAIT, the FSM shall wait until the synchronized Out_Ack equals io_Out_HS_Req.
REQ-022 On that condition: io_In_k_HS_Ack toggles, rr <= ~k, next state = IDLE, all in one edge.
REQ-023 io_Out_HS_Req shall toggle at most once per transaction; io_Out_Data shall be stable throughout WAIT.
REQ-024 Requests arriving during WAIT shall be latched only by the protocol (Req differs from Ack); none shall be lost, and arbitration shall occur in the next IDLE cycle.
REQ-025 A second Req toggle from a producer before its Ack is a protocol violation; behaviour is unspecified.
REQ-026 Latency: from an In Req edge to the Out_Req toggle = SYNC_STAGES + 1 cycles when idle; from an Out_Ack edge to the In Ack toggle = SYNC_STAGES + 1 cycles.
REQ-027 io_Busy = (state == WAIT), driven from a register with no combinational path from inputs.
REQ-028 Fairness: with both producers continuously pending, grants shall strictly alternate.

Reset
REQ-029 While reset is 0: state = IDLE; io_Out_HS_Req, both In Acks, io_Out_Data, io_Grant, io_Busy, rr (producer 0 first) and all synchronizer flops = 0.
REQ-030 Reset asserted mid-transaction shall abandon the transaction immediately; the FIFO and producers shall be reset together with this block.
REQ-031 Reset deassertion is synchronous to clock at the system level; the first transaction may start no earlier than SYNC_STAGES cycles after release.

Structure
REQ-032 Shared package hs_arb_pkg shall hold the state enum (IDLE, WAIT) and the defaults for WIDTH and SYNC_STAGES.
REQ-033 Sub-module hs_sync (parameterised N-flop synchronizer with async active-low reset) shall be instantiated three times.

Verification
Common bench setup: 10 ns clock; FIFO model returns io_Out_HS_Ack = io_Out_HS_Req delayed 5 ns.
REQ-034 Scenario 1: single transfer. In0_Req 0->1 with Data=0xA5 -> Out_Req toggles after SYNC_STAGES + 1 cycles, Out_Data=0xA5, Grant=0, In0_Ack=1 after the ack round trip.
REQ-035 Scenario 2: simultaneous requests. Both Reqs toggle in the same cycle (Data 0x11 / 0x22) -> 0x11 is sent first, then 0x22; Grant sequence 0,1.
REQ-036 Scenario 3: saturation. Both producers re-toggle immediately after each Ack for 8 transfers each -> Grant alternates 0,1,0,1..., 16 Out_Req toggles, no data lost or duplicated.
REQ-037 Scenario 4: request during WAIT. In1 toggles while In0 is in flight -> In1 is served right after In0's Ack, with no extra Out_Req toggle.
REQ-038 Scenario 5: reset mid-WAIT. Reset driven low while Busy=1 -> all outputs are 0 asynchronously; after release, a new In0 transfer of 0x3C completes normally.
REQ-039 Scenario 6: slow FIFO. Ack delay raised to 200 ns -> Out_Data holds for the whole WAIT, Busy stays 1, and the In Ack toggles only after the delayed ack.
